// File: rtl/radix4_booth_mul_hs.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides,
// per-operation signed/unsigned mode and optional accumulation into the last result.
module radix4_booth_mul_hs #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic               in_acc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               busy
);
  // state  | meaning
  // S_IDLE | waiting for an operand pair, in_ready high
  // S_BUSY | one Booth step per cycle, N_ITER cycles
  // S_DONE | result presented, held until out_ready or abort

  localparam int EW     = 2 * ((WIDTH + 2) / 2);
  localparam int N_ITER = EW / 2;
  localparam int CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam int HW     = EW + 2;
  localparam int PW     = HW + EW + 1;
  localparam logic [CW-1:0] CNT_TC = CW'(N_ITER - 1);

  if (WIDTH < 2) begin : g_width_check
    $fatal(1, "radix4_booth_mul_hs: WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              r_state;
  logic [EW-1:0]       r_a;
  logic [PW-1:0]       r_p;
  logic [CW-1:0]       r_cnt;
  logic                r_acc_flag;
  logic [2*WIDTH-1:0]  r_acc;
  logic [2*WIDTH-1:0]  r_result;
  logic                r_in_ready;
  logic                r_out_valid;
  logic                r_busy;

  logic [EW-1:0]       w_a_ext;
  logic [EW-1:0]       w_b_ext;
  logic [EW:0]         w_enc;
  logic [HW-1:0]       w_hi_sum;
  logic [PW-1:0]       w_p_sum;
  logic [PW-1:0]       w_p_next;
  logic [2*WIDTH-1:0]  w_prod;
  logic [2*WIDTH-1:0]  w_res;

  assign w_a_ext = in_signed ? {{(EW-WIDTH){in_a[WIDTH-1]}}, in_a}
                             : {{(EW-WIDTH){1'b0}}, in_a};
  assign w_b_ext = in_signed ? {{(EW-WIDTH){in_b[WIDTH-1]}}, in_b}
                             : {{(EW-WIDTH){1'b0}}, in_b};

  always_comb begin
    w_enc = '0;
    case (r_p[2:0])
      3'b001, 3'b010: w_enc = {r_a[EW-1], r_a};
      3'b011:         w_enc = {r_a, 1'b0};
      3'b100:         w_enc = -{r_a, 1'b0};
      3'b101, 3'b110: w_enc = -{r_a[EW-1], r_a};
      default:        w_enc = '0;
    endcase
  end

  // Upper field carries one guard bit beyond EW+1 so running sums never overflow.
  assign w_hi_sum = r_p[PW-1:EW+1] + {w_enc[EW], w_enc};
  assign w_p_sum  = {w_hi_sum, r_p[EW:0]};
  assign w_p_next = {{2{w_p_sum[PW-1]}}, w_p_sum[PW-1:2]};
  assign w_prod   = w_p_next[2*WIDTH:1];
  assign w_res    = w_prod + (r_acc_flag ? r_acc : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_p         <= '0;
      r_cnt       <= '0;
      r_acc_flag  <= 1'b0;
      r_acc       <= '0;
      r_result    <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && !abort) begin
            r_a        <= w_a_ext;
            r_p        <= {{HW{1'b0}}, w_b_ext, 1'b0};
            r_acc_flag <= in_acc;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (abort) begin
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CNT_TC) begin
              r_result    <= w_res;
              r_acc       <= w_res;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          // abort wins over out_ready; either way the result is retired
          if (abort || out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign busy       = r_busy;

endmodule
